// File: rtl/rs_pkg.sv
// rs_pkg: shared encodings, default widths and the entry record for the
// reservation station, plus the wakeup helpers used on the state update path.
package rs_pkg;

  localparam int RS_TAG_W = 6;
  localparam int RS_ROB_W = 6;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  typedef struct packed {
    logic                ready;
    logic [RS_TAG_W-1:0] tag;
    logic [31:0]         value;
  } rs_operand_t;

  typedef struct packed {
    logic                valid;
    logic [3:0]          alu_control;
    logic                alu_src;
    logic                is_for_lsq;
    logic [31:0]         imm;
    logic [RS_TAG_W-1:0] tag_to_output;
    logic [RS_ROB_W-1:0] rob_index;
    rs_operand_t         rs1;
    rs_operand_t         rs2;
  } rs_entry_t;

  // A waiting operand whose producer tag is broadcast picks up the value.
  function automatic rs_operand_t wake_operand(input rs_operand_t op,
                                               input logic active,
                                               input logic [RS_TAG_W-1:0] tag,
                                               input logic [31:0] value);
    wake_operand = op;
    if (!op.ready && active && (op.tag == tag)) begin
      wake_operand.ready = 1'b1;
      wake_operand.value = value;
    end
  endfunction

  // Only occupied entries snoop the broadcast; empty slots stay all-zero.
  function automatic rs_entry_t wake_entry(input rs_entry_t e,
                                           input logic active,
                                           input logic [RS_TAG_W-1:0] tag,
                                           input logic [31:0] value);
    wake_entry = e;
    if (e.valid) begin
      wake_entry.rs1 = wake_operand(e.rs1, active, tag, value);
      wake_entry.rs2 = wake_operand(e.rs2, active, tag, value);
    end
  endfunction

endpackage

// File: rtl/rs_oldest_ready_picker.sv
// rs_oldest_ready_picker: the queue is age ordered from index 0, so the
// oldest ready op is simply the lowest set bit of the ready vector.
module rs_oldest_ready_picker #(
  parameter int DEPTH = 8,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             any_ready
);

  // Scan upward and latch onto the first ready slot.
  always_comb begin
    grant     = '0;
    index     = '0;
    any_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !any_ready) begin
        any_ready = 1'b1;
        grant[i]  = 1'b1;
        index     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: collapsing issue queue in front of one functional unit.
// Ops wait until both sources are ready, the oldest ready op is handed to the
// FU in the same cycle it is selected, and younger entries shift down.
// Optional build macro RS_WAKEUP_BYPASS_EN lets the current-cycle wakeup
// broadcast make an operand ready for selection (value muxed from the bus).
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = RS_TAG_W,
  parameter int ROB_W = RS_ROB_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dispatch_valid,
  input  logic [3:0]                 dispatch_ALUControl,
  input  logic                       dispatch_ALUSrc,
  input  logic                       dispatch_is_for_lsq,
  input  logic [31:0]                dispatch_imm,
  input  logic                       dispatch_rs1_ready,
  input  logic                       dispatch_rs2_ready,
  input  logic [TAG_W-1:0]           dispatch_rs1_tag,
  input  logic [TAG_W-1:0]           dispatch_rs2_tag,
  input  logic [31:0]                dispatch_rs1_value,
  input  logic [31:0]                dispatch_rs2_value,
  input  logic [TAG_W-1:0]           dispatch_tag_to_output,
  input  logic [ROB_W-1:0]           dispatch_rob_index,
  input  logic                       wakeup_active,
  input  logic [TAG_W-1:0]           wakeup_tag,
  input  logic [31:0]                wakeup_value,
  input  logic                       fu_available,
  output logic                       issue_valid,
  output logic [3:0]                 issue_ALUControl,
  output logic                       issue_ALUSrc,
  output logic                       issue_is_for_lsq,
  output logic [31:0]                issue_imm,
  output logic [31:0]                issue_rs1_value,
  output logic [31:0]                issue_rs2_value,
  output logic [TAG_W-1:0]           issue_tag_to_output,
  output logic [ROB_W-1:0]           issue_rob_index,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  rs_entry_t        entries      [DEPTH];
  rs_entry_t        next_entries [DEPTH];
  rs_entry_t        shift_src    [DEPTH+1];
  rs_entry_t        new_entry;
  logic [DEPTH-1:0] rs1_rdy;
  logic [DEPTH-1:0] rs2_rdy;
  logic [31:0]      rs1_val      [DEPTH];
  logic [31:0]      rs2_val      [DEPTH];
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] issue_idx;
  logic             any_ready;
  logic             do_dispatch;
  logic [CNT_W-1:0] wr_pos;
  logic [CNT_W-1:0] next_count;

  assign full        = (count == CNT_W'(DEPTH));
  assign do_dispatch = dispatch_valid && !full;
  assign issue_valid = fu_available && any_ready;

  // Operand view used for selection and issue; with bypass a same-cycle
  // broadcast hit counts as ready and supplies the value directly.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic hit1;
      logic hit2;
      hit1 = BYPASS_EN && entries[i].valid && !entries[i].rs1.ready &&
             wakeup_active && (entries[i].rs1.tag == wakeup_tag);
      hit2 = BYPASS_EN && entries[i].valid && !entries[i].rs2.ready &&
             wakeup_active && (entries[i].rs2.tag == wakeup_tag);
      rs1_rdy[i]   = entries[i].rs1.ready || hit1;
      rs2_rdy[i]   = entries[i].rs2.ready || hit2;
      rs1_val[i]   = hit1 ? wakeup_value : entries[i].rs1.value;
      rs2_val[i]   = hit2 ? wakeup_value : entries[i].rs2.value;
      ready_vec[i] = entries[i].valid && rs1_rdy[i] && (rs2_rdy[i] || entries[i].alu_src);
    end
  end

  rs_oldest_ready_picker #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_picker (
    .ready     (ready_vec),
    .grant     (grant),
    .index     (issue_idx),
    .any_ready (any_ready)
  );

  // Drive the FU from the granted entry, falling back to entry 0 when idle.
  always_comb begin
    issue_ALUControl    = entries[0].alu_control;
    issue_ALUSrc        = entries[0].alu_src;
    issue_is_for_lsq    = entries[0].is_for_lsq;
    issue_imm           = entries[0].imm;
    issue_rs1_value     = rs1_val[0];
    issue_rs2_value     = rs2_val[0];
    issue_tag_to_output = entries[0].tag_to_output;
    issue_rob_index     = entries[0].rob_index;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_valid && grant[i]) begin
        issue_ALUControl    = entries[i].alu_control;
        issue_ALUSrc        = entries[i].alu_src;
        issue_is_for_lsq    = entries[i].is_for_lsq;
        issue_imm           = entries[i].imm;
        issue_rs1_value     = rs1_val[i];
        issue_rs2_value     = rs2_val[i];
        issue_tag_to_output = entries[i].tag_to_output;
        issue_rob_index     = entries[i].rob_index;
      end
    end
  end

  // Incoming op, woken by a matching broadcast so it never misses a result.
  always_comb begin
    new_entry               = '0;
    new_entry.valid         = 1'b1;
    new_entry.alu_control   = dispatch_ALUControl;
    new_entry.alu_src       = dispatch_ALUSrc;
    new_entry.is_for_lsq    = dispatch_is_for_lsq;
    new_entry.imm           = dispatch_imm;
    new_entry.tag_to_output = dispatch_tag_to_output;
    new_entry.rob_index     = dispatch_rob_index;
    new_entry.rs1.ready     = dispatch_rs1_ready;
    new_entry.rs1.tag       = dispatch_rs1_tag;
    new_entry.rs1.value     = dispatch_rs1_value;
    new_entry.rs2.ready     = dispatch_rs2_ready;
    new_entry.rs2.tag       = dispatch_rs2_tag;
    new_entry.rs2.value     = dispatch_rs2_value;
    new_entry = wake_entry(new_entry, wakeup_active, wakeup_tag, wakeup_value);
  end

  // Next queue image: wake all entries, collapse over the issued slot, then
  // append the dispatched op just above the surviving entries.
  always_comb begin
    wr_pos = count - CNT_W'(issue_valid);
    for (int i = 0; i < DEPTH; i++) begin
      shift_src[i] = wake_entry(entries[i], wakeup_active, wakeup_tag, wakeup_value);
    end
    shift_src[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_valid && (i >= int'(issue_idx))) begin
        next_entries[i] = shift_src[i+1];
      end else begin
        next_entries[i] = shift_src[i];
      end
      if (do_dispatch && (wr_pos == CNT_W'(i))) begin
        next_entries[i] = new_entry;
      end
    end
  end

  // Occupancy moves by at most one in either direction per cycle.
  always_comb begin
    next_count = count;
    case ({do_dispatch, issue_valid})
      2'b10:   next_count = count + CNT_W'(1);
      2'b01:   next_count = count - CNT_W'(1);
      default: next_count = count;
    endcase
  end

  // Queue state; reset clears whole entries so idle issue fields read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      count <= '0;
    end else begin
      entries <= next_entries;
      count   <= next_count;
    end
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Issue queue that sits directly upstream of one FunctionalUnit.
- Holds dispatched ALU ops until both source operands are available, snooping the FU wakeup broadcast for results.
- Each cycle the FU reports is_available, the block hands the oldest ready op to the FU via its write_enable-style issue interface.
- Collapsing queue: entry 0 is always the oldest.

Parameters:
DEPTH, 8, number of entries (power of two not required, ≥2)
TAG_W, 6, physical tag width
ROB_W, 6, ROB index width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all entries
dispatch_valid  in  1  write new op this cycle
dispatch_ALUControl  in  4  op encoding (0000 NOP, 0010 ADD, 1011 SRA, ...)
dispatch_ALUSrc  in  1  0: rs1 op rs2, 1: rs1 op imm
dispatch_is_for_lsq  in  1  result routed to LSQ wakeup
dispatch_imm  in  32  immediate
dispatch_rs1_ready / dispatch_rs2_ready  in  1 each  operand value already valid
dispatch_rs1_tag / dispatch_rs2_tag  in  TAG_W each  producer tag when not ready
dispatch_rs1_value / dispatch_rs2_value  in  32 each  value when ready
dispatch_tag_to_output  in  TAG_W  destination tag
dispatch_rob_index  in  ROB_W  ROB slot
wakeup_active  in  1  FU result broadcast valid
wakeup_tag  in  TAG_W  broadcast tag
wakeup_value  in  32  broadcast value
fu_available  in  1  FU is_available
issue_valid  out  1  drives FU write_enable
issue_ALUControl, issue_ALUSrc, issue_is_for_lsq, issue_imm, issue_rs1_value, issue_rs2_value, issue_tag_to_output, issue_rob_index  out  widths as dispatch  drive FU inputs
full  out  1  count == DEPTH
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: all valid bits 0; count=0; full=0; issue_valid=0; issue_* = 0. Reset overrides dispatch/wakeup/issue in the same cycle.
- Entry fields: valid, op fields, rs1/rs2 {ready, tag, value}.
- Wakeup: at posedge, for every valid entry, each not-ready operand whose tag == wakeup_tag (with wakeup_active) captures wakeup_value and sets ready. lsq_wakeup is not snooped.
- Ready: entry valid and rs1.ready and (rs2.ready or ALUSrc==1).
- Select: combinational. Lowest-index ready entry.
- issue_valid = fu_available and any ready. issue_* show the selected entry; when issue_valid=0 they show entry 0 fields (don't-care for FU).
- Issue handshake: an entry is consumed at the posedge where issue_valid=1. Zero-latency issue (same cycle the FU samples write_enable). Back-to-back issue is allowed whenever fu_available stays high (NOP case).
- Removal: entries above the issued index shift down by one, preserving age order.
- Dispatch: accepted at posedge if dispatch_valid and !full (registered full). Written at index count, or count-1 if an issue happens the same cycle. dispatch_valid while full is dropped silently; the upstream must check full.
- Dispatch + wakeup same cycle: if a not-ready dispatched operand's tag matches the active wakeup, it is stored ready with wakeup_value. A broadcast is never missed.
- Wakeup + issue same cycle on the same entry: the entry was already ready, so no conflict; shifting entries keep their updated operands.
- count updates: +1 dispatch, -1 issue, 0 both. Never exceeds DEPTH or drops below 0.

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined: an operand matching the current-cycle wakeup is treated as ready for select, and its issue value is muxed from wakeup_value. Effect: result-to-issue latency is 0 cycles.
- Undefined: entries become ready only after the wakeup posedge. Effect: 1-cycle bubble.

Decomposition:
- Package rs_pkg: ALUControl encodings (ALU_NOP=4'b0000, ALU_ADD=4'b0010, ALU_SRA=4'b1011); TAG_W/ROB_W defaults; entry struct typedef (fields listed above).
- Sub-module rs_oldest_ready_picker: DEPTH-bit ready vector in, one-hot grant plus index and any_ready out.

Test Plan:
- Reset, then fu_available=1 and no dispatch -> issue_valid=0, count=0, full=0.
- Dispatch ADD rs1=2, rs2=3 (both ready), tag 4, rob 3, fu_available=1 -> same cycle after capture: issue_valid=1, issue_rs1_value=2, issue_rs2_value=3, issue_tag_to_output=4; count back to 0 next cycle.
- Dispatch SRA with rs1 not ready (tag 7), ALUSrc=1, imm=1 -> no issue. Then wakeup_tag=7, value=-5 -> next cycle (no bypass) issue_rs1_value=-5. With RS_WAKEUP_BYPASS_EN -> issued in the wakeup cycle.
- Fill 8 entries with fu_available=0 -> full=1. A 9th dispatch is dropped (count stays 8). Raise fu_available -> entries issue in dispatch order, rob_index 0..7.
- Dispatch in the same cycle as a wakeup matching its rs2 tag -> the entry becomes ready and issues with the broadcast value.
- Simultaneous issue of entry 0 and a dispatch while count=3 -> count stays 3; the new op lands at index 2; order is preserved.
